// File: rtl/bp_stream_nbf_loader_rw.sv
// Stream NBF loader: deserialises NBF packets into AXI-lite writes/reads.
// Optional: BP_STREAM_NBF_LOADER_RESP_CHECK_EN enables sticky resp error.
module bp_stream_nbf_loader_rw #(
  parameter int axil_addr_width_p = 32,
  parameter int axil_data_width_p = 32,
  parameter int stream_data_width_p = 32,
  parameter int nbf_opcode_width_p = 8,
  parameter int nbf_addr_width_p = 40,
  parameter int nbf_data_width_p = 64,
  parameter int max_credits_p = 16
) (
  input  logic clk_i,
  input  logic reset_n_i,
  output logic done_o,
  output logic error_o,
  input  logic stream_v_i,
  input  logic [stream_data_width_p-1:0] stream_data_i,
  output logic stream_ready_o,
  output logic stream_v_o,
  output logic [stream_data_width_p-1:0] stream_data_o,
  input  logic stream_ready_i,
  output logic [axil_addr_width_p-1:0] m_axil_awaddr_o,
  output logic [2:0] m_axil_awprot_o,
  output logic m_axil_awvalid_o,
  input  logic m_axil_awready_i,
  output logic [axil_data_width_p-1:0] m_axil_wdata_o,
  output logic [axil_data_width_p/8-1:0] m_axil_wstrb_o,
  output logic m_axil_wvalid_o,
  input  logic m_axil_wready_i,
  input  logic [1:0] m_axil_bresp_i,
  input  logic m_axil_bvalid_i,
  output logic m_axil_bready_o,
  output logic [axil_addr_width_p-1:0] m_axil_araddr_o,
  output logic [2:0] m_axil_arprot_o,
  output logic m_axil_arvalid_o,
  input  logic m_axil_arready_i,
  input  logic [axil_data_width_p-1:0] m_axil_rdata_i,
  input  logic [1:0] m_axil_rresp_i,
  input  logic m_axil_rvalid_i,
  output logic m_axil_rready_o
);
  localparam int pkt_w_lp =
    nbf_opcode_width_p + nbf_addr_width_p + nbf_data_width_p;
  localparam int sw_lp = stream_data_width_p;
  localparam int flits_lp = (pkt_w_lp + sw_lp - 1) / sw_lp;
  localparam int cnt_w_lp = $clog2(flits_lp + 1);
  localparam int cred_w_lp = $clog2(max_credits_p + 1);
  localparam int strb_w_lp = axil_data_width_p / 8;
  localparam bit wide_lp = (axil_data_width_p == 64);

  typedef enum logic [2:0] {
    e_ready, e_wr_hi, e_rd_addr, e_rd_data, e_rd_out, e_done
  } state_e;

  state_e state_r, state_n;

  logic [flits_lp*sw_lp-1:0] sipo_r;
  logic [cnt_w_lp-1:0] cnt_r;
  logic full, pop, beat_done;
  logic [cred_w_lp-1:0] cred_r;
  logic cred_max, cred_zero;
  logic addr_sent_r, data_sent_r, rd_hi_r;
  logic [63:0] rdata_r;
  logic [63:0] wdata64;
  logic [7:0] wstrb8;
  logic aw_hs, w_hs, b_hs, rd_last, sel_hi;
  logic unused_bits;

  logic [nbf_opcode_width_p-1:0] op;
  logic [nbf_addr_width_p-1:0] nbf_addr;
  logic [nbf_data_width_p-1:0] data;
  logic [axil_addr_width_p-1:0] addr, addr_hi;
  logic is_wr32, is_wr64, is_rd32, is_rd64, is_fence, is_fin;

  assign {op, nbf_addr, data} = sipo_r[pkt_w_lp-1:0];
  assign addr = nbf_addr[axil_addr_width_p-1:0];
  assign addr_hi = addr + axil_addr_width_p'(4);

  assign is_wr32 = (op == nbf_opcode_width_p'(8'h02));
  assign is_wr64 = (op == nbf_opcode_width_p'(8'h03));
  assign is_rd32 = (op == nbf_opcode_width_p'(8'h12));
  assign is_rd64 = (op == nbf_opcode_width_p'(8'h13));
  assign is_fence = (op == nbf_opcode_width_p'(8'hFE));
  assign is_fin = (op == nbf_opcode_width_p'(8'hFF));

  assign full = (cnt_r == cnt_w_lp'(flits_lp));
  assign stream_ready_o = ~full;

  assign cred_max = (cred_r == cred_w_lp'(max_credits_p));
  assign cred_zero = (cred_r == '0);

  assign aw_hs = m_axil_awvalid_o & m_axil_awready_i;
  assign w_hs = m_axil_wvalid_o & m_axil_wready_i;
  assign b_hs = m_axil_bvalid_i;

  assign m_axil_bready_o = 1'b1;
  assign m_axil_awprot_o = 3'b000;
  assign m_axil_arprot_o = 3'b000;
  assign done_o = (state_r == e_done) & cred_zero;

  assign m_axil_awaddr_o = (state_r == e_wr_hi) ? addr_hi : addr;
  assign m_axil_araddr_o = rd_hi_r ? addr_hi : addr;
  assign m_axil_wdata_o = wdata64[axil_data_width_p-1:0];
  assign m_axil_wstrb_o = wstrb8[strb_w_lp-1:0];

  assign rd_last = is_rd32 | rd_hi_r;
  assign sel_hi = wide_lp & (is_rd32 ? addr[2] : rd_hi_r);
  assign stream_data_o = sel_hi ? rdata_r[63:32] : rdata_r[31:0];

  assign unused_bits = ^{sipo_r, wdata64, wstrb8, rdata_r,
                         m_axil_bresp_i, m_axil_rresp_i, nbf_addr};

  // Collect flits into the packet buffer, first flit in the LSBs
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_r <= '0;
      sipo_r <= '0;
    end else if (pop) begin
      cnt_r <= '0;
    end else if (stream_v_i && !full) begin
      for (int k = 0; k < flits_lp; k++)
        if (cnt_r == cnt_w_lp'(k))
          sipo_r[k*sw_lp +: sw_lp] <= stream_data_i;
      cnt_r <= cnt_r + 1'b1;
    end
  end

  // Outstanding-write credits: W adds one, B removes one
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)
      cred_r <= '0;
    else if (w_hs && !b_hs)
      cred_r <= cred_r + 1'b1;
    else if (!w_hs && b_hs && !cred_zero)
      cred_r <= cred_r - 1'b1;
  end

  // AW and W go out once per beat; both flags drop when the beat ends
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      addr_sent_r <= 1'b0;
      data_sent_r <= 1'b0;
    end else if (beat_done) begin
      addr_sent_r <= 1'b0;
      data_sent_r <= 1'b0;
    end else begin
      if (aw_hs) addr_sent_r <= 1'b1;
      if (w_hs) data_sent_r <= 1'b1;
    end
  end

  // Read word tracking and captured read data
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rd_hi_r <= 1'b0;
      rdata_r <= '0;
    end else begin
      if (pop)
        rd_hi_r <= 1'b0;
      else if (state_r == e_rd_out && stream_ready_i)
        rd_hi_r <= 1'b1;
      if (state_r == e_rd_data && m_axil_rvalid_i)
        rdata_r <= 64'(m_axil_rdata_i);
    end
  end

  // Write data/strobe selection for the current beat
  always_comb begin
    wdata64 = {data[31:0], data[31:0]};
    wstrb8 = 8'h0F;
    if (state_r == e_wr_hi) begin
      wdata64 = {data[63:32], data[63:32]};
    end else if (wide_lp && is_wr64) begin
      wdata64 = data[63:0];
      wstrb8 = 8'hFF;
    end else if (wide_lp && addr[2]) begin
      wstrb8 = 8'hF0;
    end
  end

  // State register
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= e_ready;
    else state_r <= state_n;
  end

  // Command sequencing and bus valids
  always_comb begin
    state_n = state_r;
    pop = 1'b0;
    beat_done = 1'b0;
    m_axil_awvalid_o = 1'b0;
    m_axil_wvalid_o = 1'b0;
    m_axil_arvalid_o = 1'b0;
    m_axil_rready_o = 1'b0;
    stream_v_o = 1'b0;
    unique case (state_r)
      e_ready: if (full) begin
        unique case (1'b1)
          is_wr32, is_wr64: begin
            m_axil_awvalid_o = ~addr_sent_r;
            m_axil_wvalid_o = ~data_sent_r & ~cred_max;
            beat_done = (addr_sent_r | m_axil_awready_i)
                      & (data_sent_r | (m_axil_wvalid_o & m_axil_wready_i));
            if (beat_done) begin
              if (is_wr64 && !wide_lp) state_n = e_wr_hi;
              else pop = 1'b1;
            end
          end
          is_rd32, is_rd64: if (cred_zero) state_n = e_rd_addr;
          is_fence, is_fin: if (cred_zero) begin
            pop = 1'b1;
            if (is_fin) state_n = e_done;
          end
          default: pop = 1'b1;
        endcase
      end
      e_wr_hi: begin
        m_axil_awvalid_o = ~addr_sent_r;
        m_axil_wvalid_o = ~data_sent_r & ~cred_max;
        beat_done = (addr_sent_r | m_axil_awready_i)
                  & (data_sent_r | (m_axil_wvalid_o & m_axil_wready_i));
        if (beat_done) begin
          pop = 1'b1;
          state_n = e_ready;
        end
      end
      e_rd_addr: begin
        m_axil_arvalid_o = 1'b1;
        if (m_axil_arready_i) state_n = e_rd_data;
      end
      e_rd_data: begin
        m_axil_rready_o = 1'b1;
        if (m_axil_rvalid_i) state_n = e_rd_out;
      end
      e_rd_out: begin
        stream_v_o = 1'b1;
        if (stream_ready_i) begin
          if (rd_last) begin
            pop = 1'b1;
            state_n = e_ready;
          end else if (!wide_lp) begin
            state_n = e_rd_addr;
          end
        end
      end
      e_done: pop = full;
      default: state_n = e_ready;
    endcase
  end

`ifdef BP_STREAM_NBF_LOADER_RESP_CHECK_EN
  logic err_r;

  // Sticky flag for any non-OKAY write or read response
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i)
      err_r <= 1'b0;
    else if ((b_hs && m_axil_bresp_i != 2'b00)
          || (m_axil_rvalid_i && m_axil_rready_o && m_axil_rresp_i != 2'b00))
      err_r <= 1'b1;
  end

  assign error_o = err_r;
`else
  assign error_o = 1'b0;
`endif

endmodule

// File: tb/tb_bp_stream_nbf_loader_rw.sv
// Bench for bp_stream_nbf_loader_rw: random AXI-lite slave plus
// packet-level reference model of expected writes and read words.
`timescale 1ns/1ps
module tb_bp_stream_nbf_loader_rw;
  localparam int MAXC = 2;

  logic clk_i = 1'b0;
  logic reset_n_i;
  logic done_o, error_o;
  logic stream_v_i, stream_ready_o;
  logic [31:0] stream_data_i;
  logic stream_v_o, stream_ready_i;
  logic [31:0] stream_data_o;
  logic [31:0] m_axil_awaddr_o, m_axil_araddr_o;
  logic [2:0] m_axil_awprot_o, m_axil_arprot_o;
  logic m_axil_awvalid_o, m_axil_awready_i;
  logic [31:0] m_axil_wdata_o;
  logic [3:0] m_axil_wstrb_o;
  logic m_axil_wvalid_o, m_axil_wready_i;
  logic [1:0] m_axil_bresp_i, m_axil_rresp_i;
  logic m_axil_bvalid_i, m_axil_bready_o;
  logic m_axil_arvalid_o, m_axil_arready_i;
  logic [31:0] m_axil_rdata_i;
  logic m_axil_rvalid_i, m_axil_rready_o;

  always #5 clk_i = ~clk_i;

  bp_stream_nbf_loader_rw #(.max_credits_p(MAXC)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .done_o(done_o), .error_o(error_o),
    .stream_v_i(stream_v_i), .stream_data_i(stream_data_i),
    .stream_ready_o(stream_ready_o),
    .stream_v_o(stream_v_o), .stream_data_o(stream_data_o),
    .stream_ready_i(stream_ready_i),
    .m_axil_awaddr_o(m_axil_awaddr_o), .m_axil_awprot_o(m_axil_awprot_o),
    .m_axil_awvalid_o(m_axil_awvalid_o), .m_axil_awready_i(m_axil_awready_i),
    .m_axil_wdata_o(m_axil_wdata_o), .m_axil_wstrb_o(m_axil_wstrb_o),
    .m_axil_wvalid_o(m_axil_wvalid_o), .m_axil_wready_i(m_axil_wready_i),
    .m_axil_bresp_i(m_axil_bresp_i), .m_axil_bvalid_i(m_axil_bvalid_i),
    .m_axil_bready_o(m_axil_bready_o),
    .m_axil_araddr_o(m_axil_araddr_o), .m_axil_arprot_o(m_axil_arprot_o),
    .m_axil_arvalid_o(m_axil_arvalid_o), .m_axil_arready_i(m_axil_arready_i),
    .m_axil_rdata_i(m_axil_rdata_i), .m_axil_rresp_i(m_axil_rresp_i),
    .m_axil_rvalid_i(m_axil_rvalid_i), .m_axil_rready_o(m_axil_rready_o)
  );

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0] s;
  } wr_t;

  int n_cmp = 0;
  int n_fail = 0;

  wr_t exp_wr[$];
  wr_t act_wr[$];
  logic [31:0] aw_q[$];
  logic [35:0] w_q[$];
  logic [31:0] exp_out[$];
  logic [31:0] act_out[$];
  logic [31:0] smem [int unsigned];
  logic [31:0] mmem [int unsigned];

  int aw_cnt, w_cnt, ar_cnt, pend_b;
  int viol_cred, viol_ovl;
  bit r_pend, rd_open, model_done, sender_done;
  bit aw_hold, w_hold, b_hold, r_hold;
  logic [31:0] r_word;
  logic [1:0] bresp_val;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hA5C3, a[15:0]};
  endfunction

  function automatic logic [31:0] mread(input logic [31:0] a);
    if (mmem.exists(a >> 2)) return mmem[a >> 2];
    return init_word(a);
  endfunction

  task automatic mwrite(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    e.s = 4'hF;
    exp_wr.push_back(e);
    mmem[a >> 2] = d;
  endtask

  // Reference: what each packet must do on a 32b bus
  task automatic model_pkt(input logic [7:0] op, input logic [31:0] a,
                           input logic [63:0] d);
    if (model_done) return;
    case (op)
      8'h02: mwrite(a, d[31:0]);
      8'h03: begin
        mwrite(a, d[31:0]);
        mwrite(a + 4, d[63:32]);
      end
      8'h12: exp_out.push_back(mread(a));
      8'h13: begin
        exp_out.push_back(mread(a));
        exp_out.push_back(mread(a + 4));
      end
      8'hFF: model_done = 1;
      default: ;
    endcase
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    smem[a >> 2] = d;
    mmem[a >> 2] = d;
  endtask

  task automatic slave_clear();
    aw_q.delete();
    w_q.delete();
    exp_wr.delete();
    act_wr.delete();
    exp_out.delete();
    act_out.delete();
    smem.delete();
    mmem.delete();
    pend_b = 0;
    r_pend = 0;
    rd_open = 0;
    model_done = 0;
  endtask

  // AXI-lite slave with random readiness plus handshake monitor
  always @(negedge clk_i) begin
    wr_t e;
    logic [35:0] wv;
    m_axil_awready_i = !aw_hold && ($urandom_range(0, 3) != 0);
    m_axil_wready_i = !w_hold && ($urandom_range(0, 3) != 0);
    m_axil_arready_i = ($urandom_range(0, 1) == 1);
    m_axil_bvalid_i = (pend_b > 0) && !b_hold && ($urandom_range(0, 2) != 0);
    m_axil_bresp_i = m_axil_bvalid_i ? bresp_val : 2'b00;
    m_axil_rvalid_i = r_pend && !r_hold && ($urandom_range(0, 2) != 0);
    m_axil_rdata_i = r_pend ? r_word : $urandom;
    m_axil_rresp_i = 2'b00;
    stream_ready_i = ($urandom_range(0, 1) == 1);
    #1;
    if (reset_n_i) begin
      if (m_axil_arvalid_o && pend_b != 0) viol_cred++;
      if (m_axil_awvalid_o && m_axil_awready_i) begin
        aw_q.push_back(m_axil_awaddr_o);
        aw_cnt++;
      end
      if (m_axil_wvalid_o && m_axil_wready_i) begin
        w_q.push_back({m_axil_wstrb_o, m_axil_wdata_o});
        w_cnt++;
        pend_b++;
      end
      if (m_axil_bvalid_i && m_axil_bready_o) pend_b--;
      if (m_axil_arvalid_o && m_axil_arready_i) begin
        if (rd_open) viol_ovl++;
        rd_open = 1;
        ar_cnt++;
        r_pend = 1;
        if (smem.exists(m_axil_araddr_o >> 2))
          r_word = smem[m_axil_araddr_o >> 2];
        else
          r_word = init_word(m_axil_araddr_o);
      end
      if (m_axil_rvalid_i && m_axil_rready_o) r_pend = 0;
      if (stream_v_o && stream_ready_i) begin
        act_out.push_back(stream_data_o);
        rd_open = 0;
      end
      while (aw_q.size() > 0 && w_q.size() > 0) begin
        wv = w_q.pop_front();
        e.a = aw_q.pop_front();
        e.d = wv[31:0];
        e.s = wv[35:32];
        smem[e.a >> 2] = e.d;
        act_wr.push_back(e);
      end
    end
  end

  task automatic send_pkt(input logic [7:0] op, input logic [39:0] a,
                          input logic [63:0] d);
    logic [127:0] p;
    int n;
    p = {16'($urandom), op, a, d};
    model_pkt(op, a[31:0], d);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      stream_v_i = 1'b1;
      stream_data_i = p[k*32 +: 32];
      n = 0;
      while (!stream_ready_o && n < 3000) begin
        @(negedge clk_i);
        n++;
      end
      if (n >= 3000) begin
        n_cmp++;
        n_fail++;
        $display("FAIL send_timeout op=%h flit=%0d ready=%b want 1",
                 op, k, stream_ready_o);
      end
      @(posedge clk_i);
    end
    @(negedge clk_i);
    stream_v_i = 1'b0;
  endtask

  task automatic check_results(input string name);
    int n = 0;
    while ((act_wr.size() < exp_wr.size() || act_out.size() < exp_out.size()
            || pend_b != 0 || r_pend) && n < 4000) begin
      @(negedge clk_i);
      n++;
    end
    repeat (6) @(negedge clk_i);
    n_cmp++;
    if (n >= 4000) begin
      n_fail++;
      $display("FAIL %s_idle got wr=%0d out=%0d want wr=%0d out=%0d",
               name, act_wr.size(), act_out.size(),
               exp_wr.size(), exp_out.size());
    end
    n_cmp++;
    if (act_wr.size() !== exp_wr.size()) begin
      n_fail++;
      $display("FAIL %s_wr_count got %0d want %0d",
               name, act_wr.size(), exp_wr.size());
    end
    for (int i = 0; i < act_wr.size() && i < exp_wr.size(); i++) begin
      n_cmp++;
      if (act_wr[i] !== exp_wr[i]) begin
        n_fail++;
        $display("FAIL %s_wr[%0d] got a=%h d=%h s=%h want a=%h d=%h s=%h",
                 name, i, act_wr[i].a, act_wr[i].d, act_wr[i].s,
                 exp_wr[i].a, exp_wr[i].d, exp_wr[i].s);
      end
    end
    n_cmp++;
    if (act_out.size() !== exp_out.size()) begin
      n_fail++;
      $display("FAIL %s_out_count got %0d want %0d",
               name, act_out.size(), exp_out.size());
    end
    for (int i = 0; i < act_out.size() && i < exp_out.size(); i++) begin
      n_cmp++;
      if (act_out[i] !== exp_out[i]) begin
        n_fail++;
        $display("FAIL %s_out[%0d] got %h want %h",
                 name, i, act_out[i], exp_out[i]);
      end
    end
    exp_wr.delete();
    act_wr.delete();
    exp_out.delete();
    act_out.delete();
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0;
    repeat (3) @(negedge clk_i);
    #2;
    n_cmp++;
    if ({m_axil_awvalid_o, m_axil_wvalid_o, m_axil_arvalid_o,
         m_axil_rready_o, stream_v_o, done_o, error_o} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got aw%b w%b ar%b r%b sv%b d%b e%b want 0",
               m_axil_awvalid_o, m_axil_wvalid_o, m_axil_arvalid_o,
               m_axil_rready_o, stream_v_o, done_o, error_o);
    end
    n_cmp++;
    if (stream_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_stream_ready got %b want 1", stream_ready_o);
    end
    n_cmp++;
    if ({m_axil_bready_o, m_axil_awprot_o, m_axil_arprot_o} !== 7'b1000000) begin
      n_fail++;
      $display("FAIL reset_consts got bready=%b awprot=%h arprot=%h want 1/0/0",
               m_axil_bready_o, m_axil_awprot_o, m_axil_arprot_o);
    end
    @(negedge clk_i);
    reset_n_i = 1'b1;
  endtask

  task automatic test_write32();
    int aw0, w0, n;
    aw0 = aw_cnt;
    w0 = w_cnt;
    aw_hold = 1;
    send_pkt(8'h02, 40'h00_8000_0000, 64'h0123_4567_DEAD_BEEF);
    n = 0;
    while (w_cnt == w0 && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    repeat (3) @(negedge clk_i);
    n_cmp++;
    if (w_cnt - w0 !== 1 || aw_cnt - aw0 !== 0 || m_axil_awvalid_o !== 1'b1) begin
      n_fail++;
      $display("FAIL w32_aw_held got w=%0d aw=%0d awvalid=%b want 1/0/1",
               w_cnt - w0, aw_cnt - aw0, m_axil_awvalid_o);
    end
    aw_hold = 0;
    check_results("w32");
    n_cmp++;
    if (aw_cnt - aw0 !== 1 || w_cnt - w0 !== 1) begin
      n_fail++;
      $display("FAIL w32_once got aw=%0d w=%0d want 1/1",
               aw_cnt - aw0, w_cnt - w0);
    end
  endtask

  task automatic test_write64();
    int aw0, w0, n;
    aw0 = aw_cnt;
    w0 = w_cnt;
    aw_hold = 1;
    send_pkt(8'h03, 40'hC3_0000_0100, 64'h1122_3344_5566_7788);
    n = 0;
    while (w_cnt == w0 && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    w_hold = 1;
    aw_hold = 0;
    n = 0;
    while (aw_cnt - aw0 < 2 && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    repeat (3) @(negedge clk_i);
    n_cmp++;
    if (stream_ready_o !== 1'b0 || act_wr.size() !== 1) begin
      n_fail++;
      $display("FAIL w64_no_early_pop got ready=%b wr=%0d want 0/1",
               stream_ready_o, act_wr.size());
    end
    w_hold = 0;
    check_results("w64");
    n_cmp++;
    if (stream_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL w64_popped got ready=%b want 1", stream_ready_o);
    end
  endtask

  task automatic test_credits();
    int w0, n;
    w0 = w_cnt;
    b_hold = 1;
    sender_done = 0;
    fork
      begin
        for (int k = 0; k < 4; k++)
          send_pkt(8'h02, {8'h00, 32'h2000 + 32'(k * 4)}, 64'($urandom));
        sender_done = 1;
      end
    join_none
    repeat (60) @(negedge clk_i);
    #2;
    n_cmp++;
    if (w_cnt - w0 !== MAXC || m_axil_wvalid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL credit_gate got w=%0d wvalid=%b want %0d/0",
               w_cnt - w0, m_axil_wvalid_o, MAXC);
    end
    b_hold = 0;
    n = 0;
    while (!sender_done && n < 3000) begin
      @(negedge clk_i);
      n++;
    end
    check_results("credits");
    n_cmp++;
    if (w_cnt - w0 !== 4) begin
      n_fail++;
      $display("FAIL credit_total got w=%0d want 4", w_cnt - w0);
    end
  endtask

  task automatic test_read();
    int ar0;
    ar0 = ar_cnt;
    preload(32'h200, 32'hAAAA_0000);
    preload(32'h204, 32'hBBBB_1111);
    b_hold = 1;
    send_pkt(8'h02, 40'h00_0000_0300, 64'($urandom));
    send_pkt(8'h13, 40'h00_0000_0200, 64'($urandom));
    repeat (30) @(negedge clk_i);
    n_cmp++;
    if (ar_cnt - ar0 !== 0 || m_axil_arvalid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL read_waits got ar=%0d arvalid=%b want 0/0",
               ar_cnt - ar0, m_axil_arvalid_o);
    end
    b_hold = 0;
    check_results("read");
    n_cmp++;
    if (ar_cnt - ar0 !== 2 || viol_cred !== 0 || viol_ovl !== 0) begin
      n_fail++;
      $display("FAIL read_order got ar=%0d cred_viol=%0d ovl_viol=%0d want 2/0/0",
               ar_cnt - ar0, viol_cred, viol_ovl);
    end
  endtask

  task automatic test_random();
    logic [7:0] ops [6];
    logic [7:0] op;
    logic [31:0] a;
    ops = '{8'h02, 8'h03, 8'h12, 8'h13, 8'hFE, 8'h5A};
    for (int k = 0; k < 40; k++) begin
      op = ops[$urandom_range(0, 5)];
      a = 32'h1000 + 32'($urandom_range(0, 15) * 4);
      send_pkt(op, {8'($urandom), a}, {$urandom, $urandom});
    end
    check_results("random");
    n_cmp++;
    if (viol_cred !== 0 || viol_ovl !== 0) begin
      n_fail++;
      $display("FAIL random_order got cred_viol=%0d ovl_viol=%0d want 0/0",
               viol_cred, viol_ovl);
    end
  endtask

  task automatic test_finish();
    int aw0, w0, n;
    b_hold = 1;
    w0 = w_cnt;
    send_pkt(8'h02, 40'h00_0000_0400, 64'h0000_0000_CAFE_F00D);
    n = 0;
    while (w_cnt == w0 && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    send_pkt(8'hFF, 40'h0, 64'h0);
    repeat (20) @(negedge clk_i);
    n_cmp++;
    if (done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL finish_wait got done=%b want 0", done_o);
    end
    b_hold = 0;
    n = 0;
    while (!done_o && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    n_cmp++;
    if (done_o !== 1'b1) begin
      n_fail++;
      $display("FAIL finish_done got done=%b want 1", done_o);
    end
    aw0 = aw_cnt;
    w0 = w_cnt;
    send_pkt(8'h02, 40'h00_0000_0500, 64'h1);
    repeat (20) @(negedge clk_i);
    n_cmp++;
    if (aw_cnt !== aw0 || w_cnt !== w0 || stream_ready_o !== 1'b1
        || done_o !== 1'b1 || m_axil_awvalid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL finish_discard got aw=%0d w=%0d rdy=%b done=%b want %0d/%0d/1/1",
               aw_cnt, w_cnt, stream_ready_o, done_o, aw0, w0);
    end
    check_results("finish");
  endtask

  task automatic test_resp_reset();
    int ar0, n;
    logic exp_err;
`ifdef BP_STREAM_NBF_LOADER_RESP_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    @(negedge clk_i);
    reset_n_i = 1'b0;
    slave_clear();
    repeat (2) @(negedge clk_i);
    reset_n_i = 1'b1;
    n_cmp++;
    if (done_o !== 1'b0 || error_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_clear got done=%b err=%b want 0/0", done_o, error_o);
    end
    bresp_val = 2'b10;
    send_pkt(8'h02, 40'h00_0000_0600, 64'h5555);
    check_results("bresp_err");
    bresp_val = 2'b00;
    n_cmp++;
    if (error_o !== exp_err) begin
      n_fail++;
      $display("FAIL resp_error got %b want %b", error_o, exp_err);
    end
    send_pkt(8'h02, 40'h00_0000_0604, 64'h6666);
    check_results("bresp_ok");
    n_cmp++;
    if (error_o !== exp_err) begin
      n_fail++;
      $display("FAIL resp_sticky got %b want %b", error_o, exp_err);
    end
    r_hold = 1;
    ar0 = ar_cnt;
    send_pkt(8'h12, 40'h00_0000_0040, 64'h0);
    n = 0;
    while (ar_cnt == ar0 && n < 500) begin
      @(negedge clk_i);
      n++;
    end
    repeat (2) @(negedge clk_i);
    #2;
    reset_n_i = 1'b0;
    #1;
    n_cmp++;
    if ({m_axil_awvalid_o, m_axil_wvalid_o, m_axil_arvalid_o,
         m_axil_rready_o, stream_v_o, done_o, error_o} !== 7'b0
        || stream_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL async_reset got aw%b w%b ar%b r%b sv%b d%b e%b rdy%b want 0..0/1",
               m_axil_awvalid_o, m_axil_wvalid_o, m_axil_arvalid_o,
               m_axil_rready_o, stream_v_o, done_o, error_o, stream_ready_o);
    end
    slave_clear();
    r_hold = 0;
    repeat (2) @(negedge clk_i);
    reset_n_i = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    stream_v_i = 1'b0;
    stream_data_i = '0;
    aw_hold = 0;
    w_hold = 0;
    b_hold = 0;
    r_hold = 0;
    bresp_val = 2'b00;
    aw_cnt = 0;
    w_cnt = 0;
    ar_cnt = 0;
    viol_cred = 0;
    viol_ovl = 0;
    slave_clear();
    test_reset();
    test_write32();
    test_write64();
    test_credits();
    test_read();
    test_random();
    test_finish();
    test_resp_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/bp_stream_nbf_loader_rw.md
Name: bp_stream_nbf_loader_rw

Overview:
- Parametrised successor to the stream NBF loader.
- Deserialises NBF packets from a 32b stream and issues AXI-lite master writes and reads into BP I/O space.
- Read data returns to the host on an outbound 32b stream.
- Supports a 32b or 64b AXI-lite data bus, a configurable write-credit depth, and read, fence and finish commands.

Parameters:
- axil_addr_width_p, 32, AXI-lite address width; NBF address truncated to this.
- axil_data_width_p, 32, AXI-lite data width; legal values 32 or 64.
- stream_data_width_p, 32, in/out stream width; must be 32.
- nbf_opcode_width_p, 8, NBF opcode field width.
- nbf_addr_width_p, 40, NBF address field width.
- nbf_data_width_p, 64, NBF data field width.
- max_credits_p, 16, maximum outstanding writes (W accepted, B not yet received).

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- done_o  out  1  finish processed and all writes acknowledged
- error_o  out  1  sticky response error (optional feature only)
- stream_v_i / stream_data_i / stream_ready_o  in/in/out  1/32/1  NBF flits in, valid-ready
- stream_v_o / stream_data_o / stream_ready_i  out/out/in  1/32/1  read data out, valid-ready
- m_axil_aw{addr,prot,valid}_o, m_axil_awready_i  axil_addr_width_p/3/1/1  write address channel
- m_axil_w{data,strb,valid}_o, m_axil_wready_i  axil_data_width_p/axil_data_width_p/8/1/1  write data channel
- m_axil_b{resp,valid}_i, m_axil_bready_o  2/1/1  write response channel
- m_axil_ar{addr,prot,valid}_o, m_axil_arready_i  axil_addr_width_p/3/1/1  read address channel
- m_axil_r{data,resp,valid}_i, m_axil_rready_o  axil_data_width_p/2/1/1  read data channel

Behaviour:
- Reset values: all valids 0, done_o 0, error_o 0, credits 0, state e_ready, SIPO empty.
- bready_o is a constant 1; awprot and arprot are 0.
- Reset asserted mid-operation abandons any AXI transaction; the slave must be reset with the loader.
- SIPO: collects ceil(112/32)=4 flits. The first flit occupies the LSBs. Packet layout is {opcode, addr, data}, with data in the LSBs.
- stream_ready_o is high while the SIPO is not full. A packet is popped only on completion of its command.
- Credits:
  - +1 on each W handshake, −1 on each B handshake.
  - Simultaneous +1 and −1 leave the count unchanged.
  - wvalid is gated low while credits == max_credits_p.
- AW and W are issued independently, each exactly once per beat, tracked by addr_sent/data_sent flags. A beat completes when both flags are set; both flags clear in that cycle.
- Opcode 0x02, 32b write:
  - 32b bus: wstrb=0xF, wdata=data[31:0].
  - 64b bus: wstrb=0x0F, or 0xF0 when addr[2]=1, with data replicated in both halves.
- Opcode 0x03, 64b write:
  - 32b bus: two beats. Low word at addr in e_ready, then high word at addr+4 in e_wr_hi. The packet pops on completion of the second beat.
  - 64b bus: one beat, wstrb=0xFF.
- Opcode 0x12 (32b read) and 0x13 (64b read):
  - Wait in e_ready until credits == 0 (reads are ordered behind writes).
  - e_rd_addr: arvalid until arready.
  - e_rd_data: rready=1; capture rdata on rvalid.
  - e_rd_out: present words on stream_data_o, low word first. 0x12 emits 1 word; 0x13 emits 2 words.
  - 64b bus with 0x12: emit the half selected by addr[2].
  - 0x13 on a 32b bus performs two AR/R rounds (addr, then addr+4), each emitted before the next AR.
  - Exactly one read is outstanding at a time. The packet pops after the last word handshake on the outbound stream.
- Opcode 0xFE, fence: pop once credits == 0.
- Opcode 0xFF, finish: pop once credits == 0, then go to e_done.
- Any other opcode: pop immediately, no bus activity.
- e_done: done_o = credits == 0. All further packets are popped and discarded, and no AXI valid is raised.
- stream_v_o stays asserted until stream_ready_i. stream_data_o is stable while stalled.

Optional Feature:
- Macro: BP_STREAM_NBF_LOADER_RESP_CHECK_EN.
- Defined: any bresp or rresp != 0 on a handshake sets error_o. error_o is sticky until reset, and reads still return rdata unchanged.
- Undefined: error_o is tied to 0 and bresp/rresp are ignored.

Test Plan:
- 32b bus, packet {0x02, 0x8000_0000, 0xDEADBEEF}, AW ready 3 cycles after W -> exactly one AW (addr 0x8000_0000) and one W (0xDEADBEEF, strb 0xF); credits 1, then 0 after B.
- 32b bus, packet 0x03 at 0x100 with data 0x11223344_55667788 -> W 0x55667788 @0x100, then W 0x11223344 @0x104; the packet pops after the second beat.
- max_credits_p=2, bvalid held low, 4 writes -> exactly 2 W handshakes and wvalid low; releasing B lets the remaining 2 proceed.
- Write then 0x13 read at 0x200 with rdata 0xAAAA0000, 0xBBBB1111 and stream_ready_i toggling -> AR waits for credits 0; out stream emits 0xAAAA0000 then 0xBBBB1111, with no second AR before the first word handshake.
- 0xFF with 1 write outstanding -> done_o stays 0 until B arrives, then goes to 1; a following 0x02 packet is consumed with no AW/W.
- Macro on: bresp=2 on one write -> error_o 1 and held; deasserting reset_n_i mid-read clears all outputs asynchronously.
